// File: rtl/rom_rd_monitor.sv
// rom_rd_monitor: passive read-side monitor for the ROM input interface.
// Each qualified address is delayed by the ROM read latency, paired with
// the returned data word and queued in a show-ahead record FIFO.
// Optional feature: define ROM_MON_CHKSUM_EN to add the running data
// checksum register and its `checksum` output port.
module rom_rd_monitor #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data,
  input  logic                     pop,
  output logic                     rec_valid,
  output logic [ADDR_W-1:0]        rec_addr,
  output logic [DATA_W-1:0]        rec_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef ROM_MON_CHKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] FULL_CNT = {1'b1, {PTR_W{1'b0}}};

  logic [LATENCY-1:0] pipe_vld;
  logic [ADDR_W-1:0]  pipe_addr [LATENCY];

  logic [ADDR_W-1:0]  mem_addr [DEPTH];
  logic [DATA_W-1:0]  mem_data [DEPTH];

  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W-1:0]   rd_idx;
  logic [PTR_W-1:0]   wr_idx;

  logic cap_vld;
  logic pop_ok;
  logic full;
  logic push_ok;
  logic drop;

  // The request leaving the last pipeline stage lines up with the ROM data
  // on this edge; a simultaneous pop frees a slot even when the FIFO is full.
  assign cap_vld   = pipe_vld[LATENCY-1];
  assign count     = wr_ptr - rd_ptr;
  assign rec_valid = (wr_ptr != rd_ptr);
  assign full      = (count == FULL_CNT);
  assign pop_ok    = pop && rec_valid;
  assign push_ok   = cap_vld && (!full || pop_ok);
  assign drop      = cap_vld && full && !pop_ok;
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign wr_idx    = wr_ptr[PTR_W-1:0];

  // Head entry is shown ahead; outputs are forced to zero while empty.
  assign rec_addr  = rec_valid ? mem_addr[rd_idx] : '0;
  assign rec_data  = rec_valid ? mem_data[rd_idx] : '0;

  // Request pipeline: stage 0 samples the bus, later stages shift along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= en;
      pipe_addr[0] <= address;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Record storage; contents need no reset since empty entries are masked.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_idx] <= pipe_addr[LATENCY-1];
      mem_data[wr_idx] <= data;
    end
  end

  // Pointer bookkeeping and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef ROM_MON_CHKSUM_EN
  // Running checksum folds in the data of every accepted record only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (push_ok) begin
      checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_rd_monitor.sv
// tb_rom_rd_monitor: scenario tasks plus randomized traffic, all checked
// against a queue-based model of the monitor kept in this bench.
module tb_rom_rd_monitor;

  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data = 8'h00;
  logic       rec_valid;
  logic [7:0] rec_addr;
  logic [7:0] rec_data;
  logic [3:0] count;
  logic       overflow;
`ifdef ROM_MON_CHKSUM_EN
  logic [7:0] checksum;
`endif

  rom_rd_monitor #(
    .ADDR_W(8), .DATA_W(8), .LATENCY(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .address(address), .data(data),
    .pop(pop), .rec_valid(rec_valid), .rec_addr(rec_addr),
    .rec_data(rec_data), .count(count), .overflow(overflow)
`ifdef ROM_MON_CHKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] a; } req_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } rec_t;

  req_t inflight[$];
  rec_t mq[$];
  bit   m_ovf;
  int   m_chk;
  int   cycle;
  int   total;
  int   bad;

  function automatic bit arriving();
    return (inflight.size() > 0) && (inflight[0].due == cycle + 1);
  endfunction

  function automatic logic [7:0] next_addr();
    return arriving() ? inflight[0].a : 8'h00;
  endfunction

  function automatic logic [7:0] e_addr();
    return (mq.size() > 0) ? mq[0].a : 8'h00;
  endfunction

  function automatic logic [7:0] e_data();
    return (mq.size() > 0) ? mq[0].d : 8'h00;
  endfunction

  function automatic logic [3:0] e_cnt();
    return 4'(mq.size());
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1ns past the edge so outputs can be sampled.
  task automatic step(input logic e, input logic [7:0] a_in,
                      input logic [7:0] d_in, input logic p);
    bit   arrive;
    bit   pop_ok;
    rec_t r;
    en = e; address = a_in; data = d_in; pop = p;
    cycle++;
    arrive = (inflight.size() > 0) && (inflight[0].due == cycle);
    pop_ok = p && (mq.size() > 0);
    if (arrive) begin
      r.a = inflight[0].a;
      r.d = d_in;
      inflight.delete(0);
      if (mq.size() < DEPTH || pop_ok) begin
        if (pop_ok) mq.delete(0);
        mq.push_back(r);
        m_chk = (((m_chk << 1) | (m_chk >> 7)) & 255) ^ int'(d_in);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (pop_ok) begin
      mq.delete(0);
    end
    if (e) inflight.push_back('{due: cycle + LAT, a: a_in});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; pop = 1'b0; address = 8'h00; data = 8'h00;
    inflight.delete();
    mq.delete();
    m_ovf = 1'b0;
    m_chk = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (rec_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0h want 0", rec_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %0h want 0", overflow); end
    total++; if (rec_addr !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr: got %0h want 0", rec_addr); end
    total++; if (rec_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %0h want 0", rec_data); end
`ifdef ROM_MON_CHKSUM_EN
    total++; if (checksum !== 8'h00) begin bad++; $display("[TB] FAIL reset_checksum: got %0h want 0", checksum); end
`endif
  endtask

  task automatic test_single_read();
    step(1'b1, 8'h05, 8'h00, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      step(1'b0, 8'h00, arriving() ? 8'hA5 : 8'h00, 1'b0);
      total++; if (rec_valid !== (mq.size() > 0)) begin bad++; $display("[TB] FAIL single_latency: got %0h want %0h (cycle %0d)", rec_valid, mq.size() > 0, i); end
    end
    total++; if (rec_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %0h want 1", rec_valid); end
    total++; if (rec_addr !== 8'h05) begin bad++; $display("[TB] FAIL single_addr: got %0h want 05", rec_addr); end
    total++; if (rec_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_data: got %0h want a5", rec_data); end
    total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL single_count: got %0d want 1", count); end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    total++; if (rec_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_valid: got %0h want 0", rec_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL single_pop_count: got %0d want 0", count); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8 + LAT; i++) begin
      if (i < 8) step(1'b1, 8'(8'h10 + i), next_addr() ^ 8'hFF, 1'b0);
      else       step(1'b0, 8'h00, next_addr() ^ 8'hFF, 1'b0);
      total++; if (count !== e_cnt()) begin bad++; $display("[TB] FAIL stream_count: got %0d want %0d", count, e_cnt()); end
    end
    total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL stream_full_count: got %0d want 8", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL stream_overflow: got %0h want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rec_addr !== 8'(8'h10 + i)) begin bad++; $display("[TB] FAIL stream_addr: got %0h want %0h", rec_addr, 8'(8'h10 + i)); end
      total++; if (rec_data !== 8'(8'hEF - i)) begin bad++; $display("[TB] FAIL stream_data: got %0h want %0h", rec_data, 8'(8'hEF - i)); end
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL stream_drained: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9 + LAT; i++) begin
      step(i < 9, 8'(8'h30 + i), 8'($urandom), 1'b0);
    end
    total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count: got %0d want 8", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %0h want 1", overflow); end
    total++; if (rec_addr !== 8'h30) begin bad++; $display("[TB] FAIL ovf_head: got %0h want 30", rec_addr); end
    total++; if (rec_data !== e_data()) begin bad++; $display("[TB] FAIL ovf_head_data: got %0h want %0h", rec_data, e_data()); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rec_addr !== e_addr()) begin bad++; $display("[TB] FAIL ovf_drain_addr: got %0h want %0h", rec_addr, e_addr()); end
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end
    total++; if (rec_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_ninth_absent: got %0h want 0", rec_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %0h want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 9 + LAT; i++) begin
      step(i < 9, (i < 8) ? 8'(8'h20 + i) : 8'h99, 8'($urandom),
           (mq.size() == DEPTH) && arriving());
      total++; if (count !== e_cnt()) begin bad++; $display("[TB] FAIL fpp_count: got %0d want %0d", count, e_cnt()); end
    end
    total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL fpp_full: got %0d want 8", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fpp_overflow: got %0h want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rec_addr !== e_addr()) begin bad++; $display("[TB] FAIL fpp_addr: got %0h want %0h", rec_addr, e_addr()); end
      total++; if (rec_data !== e_data()) begin bad++; $display("[TB] FAIL fpp_data: got %0h want %0h", rec_data, e_data()); end
      if (i == 7) begin
        total++; if (rec_addr !== 8'h99) begin bad++; $display("[TB] FAIL fpp_last: got %0h want 99", rec_addr); end
      end
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end
  endtask

  task automatic test_pop_empty();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL pop_empty_count: got %0d want 0", count); end
      total++; if (rec_valid !== 1'b0) begin bad++; $display("[TB] FAIL pop_empty_valid: got %0h want 0", rec_valid); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pop_empty_ovf: got %0h want 0", overflow); end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 8'h44, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    apply_reset();
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 8'h00, 8'h5A, 1'b0);
      total++; if (rec_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_flight_valid: got %0h want 0", rec_valid); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL rst_flight_count: got %0d want 0", count); end
      total++; if ({rec_addr, rec_data} !== 16'h0) begin bad++; $display("[TB] FAIL rst_flight_rec: got %0h want 0", {rec_addr, rec_data}); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL rst_flight_ovf: got %0h want 0", overflow); end
  endtask

  task automatic test_checksum();
`ifdef ROM_MON_CHKSUM_EN
    int n_arr;
    logic [7:0] before;
    apply_reset();
    n_arr = 0;
    for (int i = 0; i < 2 + LAT; i++) begin
      if (arriving()) begin
        n_arr++;
        step(i < 2, 8'(8'h60 + i), (n_arr == 1) ? 8'h01 : 8'h02, 1'b0);
        total++; if (checksum !== ((n_arr == 1) ? 8'h01 : 8'h00)) begin bad++; $display("[TB] FAIL chk_seq: got %0h want %0h", checksum, (n_arr == 1) ? 8'h01 : 8'h00); end
      end else begin
        step(i < 2, 8'(8'h60 + i), 8'h00, 1'b0);
      end
    end
    for (int i = 0; i < 6 + LAT; i++) begin
      step(i < 6, 8'(8'h70 + i), 8'($urandom), 1'b0);
      total++; if (checksum !== 8'(m_chk)) begin bad++; $display("[TB] FAIL chk_fill: got %0h want %0h", checksum, 8'(m_chk)); end
    end
    before = checksum;
    for (int i = 0; i < 1 + LAT; i++) begin
      step(i < 1, 8'h7F, 8'hFF, 1'b0);
    end
    total++; if (checksum !== before) begin bad++; $display("[TB] FAIL chk_drop: got %0h want %0h", checksum, before); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL chk_drop_ovf: got %0h want 1", overflow); end
`endif
  endtask

  task automatic test_random();
    int pct;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      pct = (k < 200) ? 20 : 60;
      step($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom),
           $urandom_range(0, 99) < pct);
      total++; if (count !== e_cnt()) begin bad++; $display("[TB] FAIL rnd_count: got %0d want %0d at %0d", count, e_cnt(), k); end
      total++; if (rec_valid !== (mq.size() > 0)) begin bad++; $display("[TB] FAIL rnd_valid: got %0h want %0h at %0d", rec_valid, mq.size() > 0, k); end
      total++; if (rec_addr !== e_addr()) begin bad++; $display("[TB] FAIL rnd_addr: got %0h want %0h at %0d", rec_addr, e_addr(), k); end
      total++; if (rec_data !== e_data()) begin bad++; $display("[TB] FAIL rnd_data: got %0h want %0h at %0d", rec_data, e_data(), k); end
      total++; if (overflow !== m_ovf) begin bad++; $display("[TB] FAIL rnd_ovf: got %0h want %0h at %0d", overflow, m_ovf, k); end
`ifdef ROM_MON_CHKSUM_EN
      total++; if (checksum !== 8'(m_chk)) begin bad++; $display("[TB] FAIL rnd_chk: got %0h want %0h at %0d", checksum, 8'(m_chk), k); end
`endif
    end
  endtask

  initial begin
    total = 0; bad = 0; cycle = 0; m_ovf = 1'b0; m_chk = 0;
    $display("[TB] starting rom_rd_monitor bench, LATENCY=%0d DEPTH=%0d", LAT, DEPTH);
    test_reset();
    test_single_read();
    test_streaming();
    test_overflow();
    apply_reset();
    test_full_push_pop();
    test_pop_empty();
    test_reset_inflight();
    test_checksum();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
